// File: rtl/qrisc32_mem_pkg.sv
// Shared types and defaults for the qrisc32 memory read-port arbiter.
package qrisc32_mem_pkg;

    // Which requester owns the read that is currently in flight in mem.
    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IFETCH,
        OWN_DATA
    } mem_owner_t;

    // Consecutive denied fetch cycles tolerated before fetch is forced through.
    localparam int unsigned STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_rd_arb_sat_cnt.sv
// Saturating up-counter with synchronous active-low clear and increment enable.
module sat_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: step up on enable, stick at all-ones instead of wrapping.
    always_comb begin
        // NOTE: assign a default before any branch so no path leaves cnt_d unassigned (no latch).
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
        if (!clr_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_rd_arb.sv
// Two-requester read-port arbiter in front of the shared mem instance.
// Data reads win over fetch reads, except when fetch has been denied
// STARVE_MAX cycles in a row. Writes bypass arbitration entirely.
module mem_rd_arb
    import qrisc32_mem_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    // fetch port
    input  logic             i_rd,
    input  logic [31:0]      i_addr,
    output logic             i_grant,
    output logic             i_rvalid,
    output logic [31:0]      i_rdata,
    // data port
    input  logic             d_rd,
    input  logic             d_wr,
    input  logic [31:0]      d_addr,
    input  logic [31:0]      d_wdata,
    output logic             d_grant,
    output logic             d_rvalid,
    output logic [31:0]      d_rdata,
    // mem side
    output logic [31:0]      m_add_r,
    output logic [31:0]      m_add_w,
    output logic [31:0]      m_data_w,
    output logic             m_rd,
    output logic             m_wr,
    input  logic [31:0]      m_data_r,
    // performance counters
    output logic [CNT_W-1:0] i_stall_cnt,
    output logic [CNT_W-1:0] d_stall_cnt
);

    // STARVE_MAX is limited to 1..255, so eight bits hold the run length.
    localparam logic [7:0] STARVE_LIM = STARVE_MAX[7:0];

    mem_owner_t owner_q;
    mem_owner_t owner_d;
    logic [7:0] starve_q;
    logic [7:0] starve_d;

    // Same-cycle arbitration, read address mux and next owner/starvation state.
    always_comb begin
        i_grant  = 1'b0;
        d_grant  = 1'b0;
        if (i_rd && d_rd) begin
            if (starve_q == STARVE_LIM) begin
                i_grant = 1'b1;
            end else begin
                d_grant = 1'b1;
            end
        end else begin
            i_grant = i_rd;
            d_grant = d_rd;
        end

        m_rd    = i_grant | d_grant;
        // Idle cycles keep the fetch address on the bus so it does not toggle.
        m_add_r = d_grant ? d_addr : i_addr;

        if (i_grant) begin
            owner_d = OWN_IFETCH;
        end else if (d_grant) begin
            owner_d = OWN_DATA;
        end else begin
            owner_d = OWN_NONE;
        end

        if (i_rd && !i_grant) begin
            starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 8'd1;
        end else begin
            starve_d = '0;
        end
    end

    // Owner of the in-flight read; reset drops any outstanding response.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Run length of consecutive denied fetch cycles.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    // mem returns data one cycle after the address; route it by owner.
    assign i_rvalid = (owner_q == OWN_IFETCH);
    assign d_rvalid = (owner_q == OWN_DATA);
    assign i_rdata  = m_data_r;
    assign d_rdata  = m_data_r;

    // Writes go straight to the independent mem write port.
    assign m_wr     = d_wr;
    assign m_add_w  = d_addr;
    assign m_data_w = d_wdata;

    sat_cnt #(.W(CNT_W)) u_i_stall (
        .clk   (clk),
        .clr_n (reset_n),
        .inc_i (i_rd & ~i_grant),
        .cnt_o (i_stall_cnt)
    );

    sat_cnt #(.W(CNT_W)) u_d_stall (
        .clk   (clk),
        .clr_n (reset_n),
        .inc_i (d_rd & ~d_grant),
        .cnt_o (d_stall_cnt)
    );

endmodule

// File: tb/tb_mem_rd_arb.sv
// Self-checking bench for mem_rd_arb: directed stimulus, a behavioural
// reference checked every cycle, and literal checks of key results.
// Two instances share the inputs: dut_a uses defaults (STARVE_MAX=4,
// CNT_W=16), dut_b uses STARVE_MAX=255, CNT_W=4 for counter saturation.
module tb_mem_rd_arb;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_rd, d_rd, d_wr;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [31:0] m_data_r;

    logic        a_i_grant, a_i_rvalid, a_d_grant, a_d_rvalid, a_m_rd, a_m_wr;
    logic [31:0] a_i_rdata, a_d_rdata, a_m_add_r, a_m_add_w, a_m_data_w;
    logic [15:0] a_i_stall, a_d_stall;

    logic        b_i_grant, b_i_rvalid, b_d_grant, b_d_rvalid, b_m_rd, b_m_wr;
    logic [31:0] b_i_rdata, b_d_rdata, b_m_add_r, b_m_add_w, b_m_data_w;
    logic [3:0]  b_i_stall, b_d_stall;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_rd_arb dut_a (
        .clk(clk), .reset_n(reset_n),
        .i_rd(i_rd), .i_addr(i_addr), .i_grant(a_i_grant), .i_rvalid(a_i_rvalid), .i_rdata(a_i_rdata),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_grant(a_d_grant), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
        .m_add_r(a_m_add_r), .m_add_w(a_m_add_w), .m_data_w(a_m_data_w),
        .m_rd(a_m_rd), .m_wr(a_m_wr), .m_data_r(m_data_r),
        .i_stall_cnt(a_i_stall), .d_stall_cnt(a_d_stall)
    );

    mem_rd_arb #(.STARVE_MAX(255), .CNT_W(4)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .i_rd(i_rd), .i_addr(i_addr), .i_grant(b_i_grant), .i_rvalid(b_i_rvalid), .i_rdata(b_i_rdata),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_grant(b_d_grant), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .m_add_r(b_m_add_r), .m_add_w(b_m_add_w), .m_data_w(b_m_data_w),
        .m_rd(b_m_rd), .m_wr(b_m_wr), .m_data_r(m_data_r),
        .i_stall_cnt(b_i_stall), .d_stall_cnt(b_d_stall)
    );

    // Behavioural mem attached to dut_a: registered read, read-before-write.
    logic [31:0] mem_arr [64];
    always @(posedge clk) begin
        if (a_m_rd) m_data_r <= mem_arr[a_m_add_r[7:2]];
        if (a_m_wr) mem_arr[a_m_add_w[7:2]] <= a_m_data_w;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model, compared on every falling edge ----------------
    logic [31:0] ref_mem [64];
    bit          exp_iv = 1'b0, exp_dv = 1'b0;
    logic [31:0] exp_idata, exp_ddata;
    int          run_a = 0, run_b = 0;
    int          ist_a = 0, dst_a = 0, ist_b = 0, dst_b = 0;
    bit          iw_a, dw_a, iw_b, dw_b;

    always @(negedge clk) begin
        // registered outputs reflect the model state after the last rising edge
        check("a_i_rvalid", a_i_rvalid, exp_iv);
        check("a_d_rvalid", a_d_rvalid, exp_dv);
        if (exp_iv) check("a_i_rdata", a_i_rdata, exp_idata);
        if (exp_dv) check("a_d_rdata", a_d_rdata, exp_ddata);
        check("a_i_stall", a_i_stall, ist_a);
        check("a_d_stall", a_d_stall, dst_a);
        check("b_i_stall", b_i_stall, ist_b);
        check("b_d_stall", b_d_stall, dst_b);

        // fetch wins only when alone or after STARVE_MAX straight denials
        iw_a = i_rd && (!d_rd || run_a >= 4);
        dw_a = d_rd && !iw_a;
        iw_b = i_rd && (!d_rd || run_b >= 255);
        dw_b = d_rd && !iw_b;

        check("a_i_grant", a_i_grant, iw_a);
        check("a_d_grant", a_d_grant, dw_a);
        check("a_m_rd", a_m_rd, iw_a || dw_a);
        if (iw_a || dw_a) check("a_m_add_r", a_m_add_r, dw_a ? d_addr : i_addr);
        check("b_i_grant", b_i_grant, iw_b);
        check("b_d_grant", b_d_grant, dw_b);
        check("b_m_rd", b_m_rd, iw_b || dw_b);
        check("a_m_wr", a_m_wr, d_wr);
        if (d_wr) begin
            check("a_m_add_w", a_m_add_w, d_addr);
            check("a_m_data_w", a_m_data_w, d_wdata);
        end

        // advance the model to the state after the coming rising edge
        if (!reset_n) begin
            exp_iv = 1'b0; exp_dv = 1'b0;
            run_a = 0; run_b = 0;
            ist_a = 0; dst_a = 0; ist_b = 0; dst_b = 0;
        end else begin
            exp_iv = iw_a;
            exp_dv = dw_a;
            if (iw_a) exp_idata = ref_mem[i_addr[7:2]];
            if (dw_a) exp_ddata = ref_mem[d_addr[7:2]];
            run_a = (i_rd && !iw_a) ? run_a + 1 : 0;
            run_b = (i_rd && !iw_b) ? run_b + 1 : 0;
            if (i_rd && !iw_a && ist_a < 65535) ist_a++;
            if (d_rd && !dw_a && dst_a < 65535) dst_a++;
            if (i_rd && !iw_b && ist_b < 15) ist_b++;
            if (d_rd && !dw_b && dst_b < 15) dst_b++;
        end
        // the write lands at the same edge, after the read has sampled old data
        if (d_wr) ref_mem[d_addr[7:2]] = d_wdata;
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_rd = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        i_addr = '0; d_addr = '0; d_wdata = '0;
        step();

        // Preload words 0..7 through the write passthrough while in reset.
        for (int k = 0; k < 8; k++) begin
            d_wr    = 1'b1;
            d_addr  = 32'(k * 4);
            d_wdata = (k == 5) ? 32'hDEADBEEF : (k == 3) ? 32'hCAFEF00D : 32'hA5000000 | 32'(k);
            step();
        end
        idle();

        // 1. Reset held with both reads requested: no rvalid, counters zero.
        i_rd = 1'b1; d_rd = 1'b1; i_addr = 32'h14; d_addr = 32'h04;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_i_rvalid", a_i_rvalid, 1'b0);
            check("rst_d_rvalid", a_d_rvalid, 1'b0);
            check("rst_i_stall", a_i_stall, 32'd0);
            check("rst_d_stall", a_d_stall, 32'd0);
            step();
        end
        reset_n = 1'b1;
        @(negedge clk);
        check("rel_d_grant", a_d_grant, 1'b1);
        check("rel_d_rvalid_early", a_d_rvalid, 1'b0);
        step();
        idle();
        @(negedge clk);
        check("rel_d_rvalid", a_d_rvalid, 1'b1);
        check("rel_d_rdata", a_d_rdata, 32'hA5000001);
        step();

        // 2. Single fetch of word 5.
        i_rd = 1'b1; i_addr = 32'h14;
        @(negedge clk);
        check("sf_i_grant", a_i_grant, 1'b1);
        step();
        idle();
        @(negedge clk);
        check("sf_i_rvalid", a_i_rvalid, 1'b1);
        check("sf_i_rdata", a_i_rdata, 32'hDEADBEEF);
        check("sf_d_rvalid", a_d_rvalid, 1'b0);
        step();

        // 3. Starvation: both requesting for 20 cycles -> D,D,D,D,I repeating.
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        i_rd = 1'b1; d_rd = 1'b1; i_addr = 32'h14; d_addr = 32'h0C;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("stv_i_grant", a_i_grant, (k % 5) == 4);
            step();
        end
        idle();
        @(negedge clk);
        check("stv_d_stall", a_d_stall, 32'd4);
        check("stv_i_stall", a_i_stall, 32'd16);
        step();

        // 4. Write then read of 0x08, then same-cycle read+write of 0x0C.
        d_wr = 1'b1; d_addr = 32'h08; d_wdata = 32'h12345678;
        step();
        d_wr = 1'b0; d_rd = 1'b1;
        step();
        idle();
        @(negedge clk);
        check("raw_d_rvalid", a_d_rvalid, 1'b1);
        check("raw_d_rdata", a_d_rdata, 32'h12345678);
        step();
        d_rd = 1'b1; d_wr = 1'b1; d_addr = 32'h0C; d_wdata = 32'h55AA55AA;
        step();
        idle();
        @(negedge clk);
        check("rbw_old_data", a_d_rdata, 32'hCAFEF00D);
        step();
        d_rd = 1'b1; d_addr = 32'h0C;
        step();
        idle();
        @(negedge clk);
        check("rbw_new_data", a_d_rdata, 32'h55AA55AA);
        step();

        // 5. Counter saturation on dut_b (CNT_W=4, STARVE_MAX=255).
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        i_rd = 1'b1; d_rd = 1'b1; i_addr = 32'h14; d_addr = 32'h00;
        for (int k = 0; k < 20; k++) step();
        idle();
        @(negedge clk);
        check("sat_b_i_stall", b_i_stall, 32'd15);
        check("sat_b_d_stall", b_d_stall, 32'd0);
        step();
        @(negedge clk);
        check("sat_b_i_hold", b_i_stall, 32'd15);
        step();

        // 6. Fetch granted while reset is sampled at the following edge.
        i_rd = 1'b1; i_addr = 32'h14; reset_n = 1'b0;
        @(negedge clk);
        check("mtr_i_grant", a_i_grant, 1'b1);
        step();
        idle();
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("mtr_i_rvalid", a_i_rvalid, 1'b0);
            check("mtr_d_rvalid", a_d_rvalid, 1'b0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
